seg_scan_driver: RTL



---
 rtl/calc_disp_pkg.sv | 17 +
 rtl/seg_scan_tick.sv | 44 ++++
 rtl/seg_scan_driver.sv | 119 +++++++++++
 3 files changed

// File: rtl/calc_disp_pkg.sv
// Shared constants for the calculator display path:
// seven-segment glyphs and scan slot encodings.
package calc_disp_pkg;

  localparam int NUM_SLOTS = 5;

  localparam logic [6:0] GLYPH_ZERO  = 7'b0111111;
  localparam logic [6:0] GLYPH_MINUS = 7'b1000000;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  localparam logic [2:0] SLOT_A    = 3'd0;
  localparam logic [2:0] SLOT_B    = 3'd1;
  localparam logic [2:0] SLOT_SIGN = 3'd2;
  localparam logic [2:0] SLOT_TEN  = 3'd3;
  localparam logic [2:0] SLOT_ONE  = 3'd4;

endpackage

// File: rtl/seg_scan_tick.sv
// Slot-time divider: tick within a slot, slot index,
// and wrap / last-slot strobes. Holds while disabled.
module seg_scan_tick
  import calc_disp_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int TW      = $clog2(CLK_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  output logic [TW-1:0] o_tick,
  output logic [2:0]    o_slot,
  output logic          o_wrap,
  output logic          o_last
);

  logic [TW-1:0] r_tick;
  logic [2:0]    r_slot;
  logic          w_wrap;

  assign w_wrap = i_en && (r_tick == TW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick <= '0;
      r_slot <= SLOT_A;
    end else if (i_en) begin
      if (w_wrap) begin
        r_tick <= '0;
        r_slot <= (r_slot >= SLOT_ONE) ? SLOT_A
                                       : r_slot + 3'd1;
      end else begin
        r_tick <= r_tick + TW'(1);
      end
    end
  end

  assign o_tick = r_tick;
  assign o_slot = r_slot;
  assign o_wrap = w_wrap;
  assign o_last = w_wrap && (r_slot == SLOT_ONE);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexes A, B, sign, tens and ones onto one
// active-low segment bus with per-frame snapshots.
module seg_scan_driver
  import calc_disp_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int DEAD_CYCLES    = 8,
  parameter int BLANK_TEN_ZERO = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] seg_a,
  input  logic [6:0] seg_b,
  input  logic [6:0] seg_ten,
  input  logic [6:0] seg_one,
  input  logic       neg,
  output logic [6:0] seg_n,
  output logic [4:0] an_n,
  output logic       frame_done
);

  localparam int TW = $clog2(CLK_DIV);

  logic [TW-1:0] w_tick;
  logic [2:0]    w_slot;
  logic          w_wrap;
  logic          w_last;

  seg_scan_tick #(
    .CLK_DIV (CLK_DIV),
    .TW      (TW)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (en),
    .o_tick (w_tick),
    .o_slot (w_slot),
    .o_wrap (w_wrap),
    .o_last (w_last)
  );

  logic [6:0] r_a, r_b, r_ten, r_one;
  logic       r_neg;
  logic       r_first;
  logic [6:0] r_seg_n;
  logic [4:0] r_an_n;
  logic       r_fd;

  logic [6:0] w_pat;
  logic [4:0] w_an_n;
  logic       w_valid;
  logic       w_lit;
  logic       w_load;

  assign w_lit  = int'(w_tick) >= DEAD_CYCLES;
  assign w_load = en && (r_first || w_last);

  always_comb begin
    w_pat   = GLYPH_BLANK;
    w_an_n  = 5'h1F;
    w_valid = 1'b1;
    unique case (w_slot)
      SLOT_A:    w_pat = r_a;
      SLOT_B:    w_pat = r_b;
      SLOT_SIGN: w_pat = r_neg ? GLYPH_MINUS
                               : GLYPH_BLANK;
      SLOT_TEN:  w_pat = (BLANK_TEN_ZERO != 0 &&
                          r_ten == GLYPH_ZERO)
                         ? GLYPH_BLANK : r_ten;
      SLOT_ONE:  w_pat = r_one;
      default:   w_valid = 1'b0;
    endcase
    if (w_valid) w_an_n = ~(5'b00001 << w_slot);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_ten   <= '0;
      r_one   <= '0;
      r_neg   <= 1'b0;
      r_first <= 1'b1;
      r_seg_n <= 7'h7F;
      r_an_n  <= 5'h1F;
      r_fd    <= 1'b0;
    end else begin
      // Snapshot lands with the slot wrap so slot0 sees it.
      if (w_load) begin
        r_a     <= seg_a;
        r_b     <= seg_b;
        r_ten   <= seg_ten;
        r_one   <= seg_one;
        r_neg   <= neg;
        r_first <= 1'b0;
      end
      if (!en) begin
        r_seg_n <= 7'h7F;
        r_an_n  <= 5'h1F;
        r_fd    <= 1'b0;
      end else begin
        r_fd <= w_last;
        if (w_lit && w_valid) begin
          r_seg_n <= ~w_pat;
          r_an_n  <= w_an_n;
        end else begin
          r_seg_n <= 7'h7F;
          r_an_n  <= 5'h1F;
        end
      end
    end
  end

  assign seg_n      = r_seg_n;
  assign an_n       = r_an_n;
  assign frame_done = r_fd;

endmodule
